// File: rtl/fir_direct.sv
// fir_direct: 11-tap symmetric low-pass FIR filter with fixed coefficients.
// One sample in and one registered result out per clock. There is no handshake.
// The multiply-accumulate is combinational in front of the output register.
// The symmetric taps are folded so that each coefficient pair shares one multiply.
// The result is floor(sum(h[k]*x[n-k]) / 2^SHIFT).
// Note: rst_n is active-high despite its name. It is sampled on the rising clock edge.
module fir_direct #(
  parameter int INWL   = 15,
  parameter int MACWL  = 20,
  parameter int COEFWL = 8,
  parameter int SHIFT  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [INWL-1:0]  data_in,
  output logic signed [MACWL-1:0] data_out
);

  localparam int NTAPS  = 11;
  localparam int NPAIRS = NTAPS / 2;
  // A 23-bit product plus growth over 11 taps fits comfortably in 27 bits.
  localparam int ACCWL  = INWL + COEFWL + 4;

  // Fixed coefficient table. It is symmetric around the centre tap and sums to 64.
  function automatic logic signed [COEFWL-1:0] coefAt(input int k);
    case (k)
      0, 10:   coefAt = COEFWL'(1);
      2, 8:    coefAt = COEFWL'(-5);
      4, 6:    coefAt = COEFWL'(20);
      5:       coefAt = COEFWL'(32);
      default: coefAt = '0;
    endcase
  endfunction

  // tap_q[k] holds x[n-k] for k = 1..10.
  logic signed [INWL-1:0]  tap_q [1:NTAPS-1];
  logic signed [INWL-1:0]  x     [0:NTAPS-1];
  logic signed [ACCWL-1:0] acc;
  logic signed [MACWL-1:0] data_out_d;
  logic signed [MACWL-1:0] data_out_q;

  // Gather the current sample and the delay line into one indexable window.
  always_comb begin
    x[0] = data_in;
    for (int k = 1; k < NTAPS; k++) begin
      x[k] = tap_q[k];
    end
  end

  // Folded multiply-accumulate.
  // Mirrored taps are pre-added, then multiplied by their shared coefficient.
  // The arithmetic shift rounds toward minus infinity.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NPAIRS; k++) begin
      acc = acc + (ACCWL'(x[k]) + ACCWL'(x[NTAPS-1-k])) * ACCWL'(coefAt(k));
    end
    acc = acc + ACCWL'(x[NPAIRS]) * ACCWL'(coefAt(NPAIRS));
    data_out_d = MACWL'(acc >>> SHIFT);
  end

  // Advance the delay line and register the filtered result.
  // A reset clears all history, and the incoming sample is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 1; k < NTAPS; k++) begin
        tap_q[k] <= '0;
      end
      data_out_q <= '0;
    end else begin
      tap_q[1] <= data_in;
      for (int k = 2; k < NTAPS; k++) begin
        tap_q[k] <= tap_q[k-1];
      end
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_fir_direct.sv
// tb_fir_direct: scoreboard bench for fir_direct.
// Each driven sample pushes its expected output onto a queue.
// The expected value comes from an integer reference model or a literal table.
// The next falling edge pops the entry and compares it against data_out.
module tb_fir_direct;

  logic               clk;
  logic               rstN;
  logic signed [14:0] dataIn;
  logic signed [19:0] dataOut;

  int compareCount;
  int failCount;

  int coefTable [0:10] = '{1, 0, -5, 0, 20, 32, 20, 0, -5, 0, 1};
  int prevX [1:10];

  logic signed [19:0] expQueue [$];
  string              tagQueue [$];

  fir_direct dut (
    .clk      (clk),
    .rst_n    (rstN),
    .data_in  (dataIn),
    .data_out (dataOut)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic signed [19:0] observed,
                             input logic signed [19:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Compare the output of the previous edge against the oldest queued expectation.
  task automatic popAndCheck();
    logic signed [19:0] e;
    string t;
    if (expQueue.size() > 0) begin
      e = expQueue.pop_front();
      t = tagQueue.pop_front();
      checkOutput(t, dataOut, e);
    end
  endtask

  // Run the reference model for one sample.
  // The division floors explicitly, so the model does not rely on a shift.
  function automatic int modelY(input int s);
    int sum;
    int q;
    sum = coefTable[0] * s;
    for (int k = 1; k <= 10; k++) begin
      sum += coefTable[k] * prevX[k];
    end
    q = sum / 64;
    if ((sum % 64 != 0) && (sum < 0)) begin
      q = q - 1;
    end
    return q;
  endfunction

  // On a falling edge: check the pending result, then drive the new sample and reset.
  // The expected value is queued from the model, unless a literal golden value is supplied.
  task automatic applyStimulus(input logic signed [14:0] s, input logic rst,
                               input logic useGold, input int gold, input string tag);
    int y;
    @(negedge clk);
    popAndCheck();
    dataIn = s;
    rstN   = rst;
    if (rst) begin
      y = 0;
      for (int k = 1; k <= 10; k++) prevX[k] = 0;
    end else begin
      y = modelY(int'(s));
      for (int k = 10; k >= 2; k--) prevX[k] = prevX[k-1];
      prevX[1] = int'(s);
    end
    expQueue.push_back(useGold ? 20'(gold) : 20'(y));
    tagQueue.push_back(tag);
  endtask

  int impulseGold [0:13] = '{1, 0, -5, 0, 20, 32, 20, 0, -5, 0, 1, 0, 0, 0};
  int stepGold    [0:13] = '{1, 1, -4, -4, 16, 48, 68, 68, 63, 63, 64, 64, 64, 64};
  int unitGold    [0:12] = '{0, 0, -1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0};

  initial begin
    compareCount = 0;
    failCount    = 0;
    for (int k = 1; k <= 10; k++) prevX[k] = 0;
    rstN   = 1'b1;
    dataIn = '0;

    // The reset state must read 0, even with junk on the input.
    for (int i = 0; i < 3; i++) applyStimulus(15'($urandom), 1'b1, 1'b1, 0, "reset");

    // Impulse of +64 reproduces the coefficient table.
    for (int i = 0; i < 14; i++)
      applyStimulus((i == 0) ? 15'sd64 : 15'sd0, 1'b0, 1'b1, impulseGold[i], "impulse64");

    // Step of +64 from a cleared state.
    applyStimulus(15'sd0, 1'b1, 1'b1, 0, "reset");
    for (int i = 0; i < 14; i++)
      applyStimulus(15'sd64, 1'b0, 1'b1, stepGold[i], "step64");

    // Impulse of +1: the negative taps must floor to -1.
    applyStimulus(15'sd0, 1'b1, 1'b1, 0, "reset");
    for (int i = 0; i < 13; i++)
      applyStimulus((i == 0) ? 15'sd1 : 15'sd0, 1'b0, 1'b1, unitGold[i], "impulse1");

    // Extreme positive constant must settle at 16383 without wrapping.
    applyStimulus(15'sd0, 1'b1, 1'b1, 0, "reset");
    for (int i = 0; i < 16; i++)
      applyStimulus(15'sd16383, 1'b0, (i >= 10), 16383, "constPos");

    // Extreme negative constant must settle at -16384.
    applyStimulus(15'sd0, 1'b1, 1'b1, 0, "reset");
    for (int i = 0; i < 16; i++)
      applyStimulus(-15'sd16384, 1'b0, (i >= 10), -16384, "constNeg");

    // Random stream with a reset pulse in the middle.
    // The model restarts from zero state at that point.
    applyStimulus(15'sd0, 1'b1, 1'b1, 0, "reset");
    for (int i = 0; i < 500; i++) begin
      if (i == 250 || i == 251)
        applyStimulus(15'($urandom), 1'b1, 1'b1, 0, "midReset");
      else
        applyStimulus(15'($urandom), 1'b0, 1'b0, 0, "random");
    end

    // Drain the last expectation.
    @(negedge clk);
    popAndCheck();
    if (expQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQueue.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fir_direct.md
# fir_direct

Fixed-coefficient, 11-tap, direct-form low-pass FIR filter on a single clock. It processes one signed 15-bit sample per cycle with no handshake. It produces one registered signed 20-bit result per cycle. It sits in the DSP datapath between the sample source and downstream processing, and its output is compared sample-for-sample against the fixed-point golden model.

## Interface
- INWL, 15: input sample width (signed two's complement).
- MACWL, 20: output width (signed two's complement).
- COEFWL, 8: coefficient width (signed integer).
- SHIFT, 6: arithmetic right shift applied to the accumulator (coefficient scale 1/64).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous and active-high, despite the `_n` suffix.
- data_in  input  INWL  signed input sample; a new sample every cycle.
- data_out  output  MACWL  signed filtered sample; registered.

## Operation
- Coefficients are a fixed internal table, symmetric, summing to 64 (DC gain 1).
  - h[0..10] = 1, 0, -5, 0, 20, 32, 20, 0, -5, 0, 1.
- Delay line holds x[n-1]..x[n-10]; x[n] is the current `data_in`.
- y[n] = floor( (Σ_{k=0..10} h[k]·x[n-k]) / 2^SHIFT ).
  - Computed as an arithmetic right shift, so values round toward minus infinity (not toward zero).
- Arithmetic rules:
  - Products are full precision: INWL+COEFWL = 23 bits signed.
  - The accumulator is at least 27 bits signed, so there is no intermediate overflow.
  - The shifted result is sign-extended or truncated to MACWL bits.
  - No saturation is needed: max |y| = 16384·84/64 = 21504, which fits in 20 bits.
- Each rising edge with reset low:
  - the delay line shifts by one;
  - `data_in` enters at x[n-1];
  - `data_out` loads y[n] computed from the pre-edge `data_in` and the pre-edge delay line.
- Reset high at a rising edge:
  - every delay-line register and `data_out` is cleared to 0;
  - `data_in` is ignored, not shifted in.
- After reset, the filter behaves as if all previous inputs were 0.
- An X or undriven `data_in` before the first valid sample propagates through the delay line normally; no X filtering is done.

## Timing
- Throughput: one sample per clock, no stalls, no valid/ready.
- Latency: the sample present at `data_in` before rising edge t contributes to `data_out` right after edge t.
  - One registered stage, with the multiply-accumulate combinational in front of it.
- `data_out` is constant between rising edges; sampling it just before edge t+1 yields y for the input captured at edge t.
- Reset value of `data_out`: 0.
- `data_out` reads 0 through the first cycle after reset release, until the first edge with reset low.
- Reset mid-stream:
  - the next edge clears all state;
  - outputs following release depend only on inputs captured after release.
- The input is driven on the falling clock edge; the design needs no setup margin beyond a half cycle.

## Test plan
- Impulse +64 then zeros -> `data_out` sequence 1, 0, -5, 0, 20, 32, 20, 0, -5, 0, 1, then 0 forever.
- Step of +64 from all-zero state -> 1, 1, -4, -4, 16, 48, 68, 68, 63, 63, 64, then 64 steady.
- Impulse +1 (floor check) -> 0, 0, -1, 0, 0, 0, 0, 0, -1, 0, 0.
  - The -1 values confirm floor rounding, not truncation toward zero.
- Constant +16383 and constant -16384 -> steady-state 16383 and -16384 respectively.
  - No wrap in the 20-bit output at extreme input magnitudes.
- Reset in the middle of a random 500-sample stream -> `data_out` is 0 on the edge after reset.
  - Subsequent outputs must match the golden model restarted from zero state at reset release.
- Random 500-sample signed 15-bit stream -> every output equals the bit-exact reference y[n] at one-cycle latency; zero mismatches.
